pll_lock_ctrl: RTL and testbench

// - Reset/lock sequencer wrapped around the CRG PLL wrapper, clocked by the PLL reference clock clk_in0.
// - Drives the PLL's active-high reset with a minimum-width pulse and qualifies its async locked output.
// - Retries on lock timeout and releases the system reset sys_rst_n only after stable lock plus a delay.
// - Re-sequences on lock loss and latches a fault after exhausted retries.

---
 rtl/pll_lock_ctrl_pkg.sv | 30 +++
 rtl/pll_lock_ctrl_if.sv | 33 +++
 rtl/pll_lock_ctrl_sync_2ff.sv | 23 ++
 rtl/pll_lock_ctrl.sv | 156 +++++++++++++++
 tb/tb_pll_lock_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/pll_lock_ctrl_pkg.sv
// pll_lock_ctrl_pkg: state encoding, relock counter width and
// a width helper shared by the PLL reset/lock sequencer files.
package pll_lock_ctrl_pkg;

  localparam int RELOCK_W = 8;

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4,
    S_FAULT     = 3'd5
  } state_e;

  function automatic int max4(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/pll_lock_ctrl_if.sv
// pll_lock_ctrl_if: PLL-side and system-side signals of the sequencer.
// master = sequencer (drives resets/status), slave = PLL + system.
interface pll_lock_ctrl_if;
  import pll_lock_ctrl_pkg::*;

  logic                pll_locked;
  logic                restart;
  logic                pll_reset;
  logic                sys_rst_n;
  logic                ready;
  logic                fault;
  logic [RELOCK_W-1:0] relock_cnt;

  modport master (
    input  pll_locked,
    input  restart,
    output pll_reset,
    output sys_rst_n,
    output ready,
    output fault,
    output relock_cnt
  );

  modport slave (
    output pll_locked,
    output restart,
    input  pll_reset,
    input  sys_rst_n,
    input  ready,
    input  fault,
    input  relock_cnt
  );
endinterface

// File: rtl/pll_lock_ctrl_sync_2ff.sv
// sync_2ff: 1-bit two-flop synchroniser, async active-low reset to 0.
// Ports: clk_i, rst_ni, d_i (async in), q_o (synced, 2-cycle latency).
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;
endmodule

// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: PLL reset pulse, lock qualification, retry/fault and
// sys_rst_n release. Ports: clk_in0, reset_n, bus (pll_lock_ctrl_if.master).
module pll_lock_ctrl
  import pll_lock_ctrl_pkg::*;
#(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int RELEASE_DLY_CYC  = 64,
  parameter int MAX_RETRIES      = 4
) (
  input  logic           clk_in0,
  input  logic           reset_n,
  pll_lock_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(max4(RST_PULSE_CYC, LOCK_TIMEOUT_CYC,
                                     LOCK_STABLE_CYC, RELEASE_DLY_CYC)) + 1;
  localparam int RET_W = $clog2(MAX_RETRIES + 2);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_DLY_CYC - 1);
  localparam logic [RET_W-1:0] RET_MAX  = RET_W'(MAX_RETRIES);

  logic                locked_s;
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RET_W-1:0]    retries_q, retries_d;
  logic [RELOCK_W-1:0] relock_q, relock_d;
  logic                pll_reset_q;
  logic                sys_rst_n_q;
  logic                ready_q;
  logic                fault_q;
  logic                fail;

  sync_2ff u_sync (
    .clk_i  (clk_in0),
    .rst_ni (reset_n),
    .d_i    (bus.pll_locked),
    .q_o    (locked_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retries_d = retries_q;
    relock_d  = relock_q;
    fail      = 1'b0;
    if (bus.restart) begin
      state_d   = S_RESET_PLL;
      cnt_d     = '0;
      retries_d = '0;
    end else begin
      case (state_q)
        S_RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            fail = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_STABLE: begin
          if (!locked_s) begin
            fail = 1'b1;
          end else if (cnt_q == ST_LAST) begin
            state_d = S_RELEASE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RELEASE: begin
          if (!locked_s) begin
            state_d   = S_RESET_PLL;
            cnt_d     = '0;
            retries_d = '0;
          end else if (cnt_q == REL_LAST) begin
            state_d   = S_RUN;
            cnt_d     = '0;
            retries_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            state_d   = S_RESET_PLL;
            cnt_d     = '0;
            retries_d = '0;
            if (relock_q != '1) relock_d = relock_q + RELOCK_W'(1);
          end
        end
        S_FAULT: ;
        default: begin
          state_d   = S_RESET_PLL;
          cnt_d     = '0;
          retries_d = '0;
        end
      endcase
      // A failed attempt either retries with a fresh pulse or gives up.
      if (fail) begin
        cnt_d = '0;
        if (retries_q == RET_MAX) begin
          state_d = S_FAULT;
        end else begin
          state_d   = S_RESET_PLL;
          retries_d = retries_q + RET_W'(1);
        end
      end
    end
  end

  // Outputs are decoded from the next state so they change on the
  // same edge as the state itself.
  always_ff @(posedge clk_in0 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      retries_q   <= '0;
      relock_q    <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retries_q   <= retries_d;
      relock_q    <= relock_d;
      pll_reset_q <= (state_d == S_RESET_PLL) || (state_d == S_FAULT);
      sys_rst_n_q <= (state_d == S_RUN);
      ready_q     <= (state_d == S_RUN);
      fault_q     <= (state_d == S_FAULT);
    end
  end

  assign bus.pll_reset  = pll_reset_q;
  assign bus.sys_rst_n  = sys_rst_n_q;
  assign bus.ready      = ready_q;
  assign bus.fault      = fault_q;
  assign bus.relock_cnt = relock_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// tb_pll_lock_ctrl: directed sequence for pll_lock_ctrl with a
// queue of expected values popped as outputs are observed.
module tb_pll_lock_ctrl;

  logic clk_in0 = 1'b0;
  logic reset_n;

  always #5 clk_in0 = ~clk_in0;

  pll_lock_ctrl_if bus ();

  pll_lock_ctrl #(
    .RST_PULSE_CYC    (4),
    .LOCK_TIMEOUT_CYC (100),
    .LOCK_STABLE_CYC  (8),
    .RELEASE_DLY_CYC  (4),
    .MAX_RETRIES      (2)
  ) dut (
    .clk_in0 (clk_in0),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sbq[$];
  int   passed = 0;
  int   total  = 0;

  task automatic push(input string tag, input int val);
    sbq.push_back('{tag, val});
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sbq.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === 32'(e.val)) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk_in0);
    #1;
  endtask

  task automatic width_while(input logic lvl, input int lim, output int n);
    n = 0;
    while (bus.pll_reset === lvl && n < lim) begin
      tick();
      n++;
    end
  endtask

  task automatic until_sysrst(input int lim, output int n);
    n = 0;
    while (bus.sys_rst_n !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
  endtask

  task automatic until_ready(input int lim, output int n);
    n = 0;
    while (bus.ready !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int n;
    int tmo;
    logic hi;

    reset_n        = 1'b0;
    bus.pll_locked = 1'b0;
    bus.restart    = 1'b0;
    repeat (3) tick();

    push("rst_pll_reset", 1);  check(32'(bus.pll_reset));
    push("rst_sys_rst_n", 0);  check(32'(bus.sys_rst_n));
    push("rst_ready", 0);      check(32'(bus.ready));
    push("rst_fault", 0);      check(32'(bus.fault));
    push("rst_relock", 0);     check(32'(bus.relock_cnt));

    // Clean lock
    reset_n = 1'b1;
    push("first_pulse_w", 4);
    width_while(1'b1, 50, n);
    check(n);
    repeat (19) tick();
    bus.pll_locked = 1'b1;
    tick();
    push("lock_to_run", 2 + 8 + 4);
    until_sysrst(50, n);
    check(n);
    push("clean_ready", 1);    check(32'(bus.ready));
    push("clean_relock", 0);   check(32'(bus.relock_cnt));

    // Glitchy lock: restart wins over the lock drop
    bus.restart    = 1'b1;
    bus.pll_locked = 1'b0;
    tick();
    bus.restart = 1'b0;
    push("rs_sys_rst_n", 0);   check(32'(bus.sys_rst_n));
    push("rs_ready", 0);       check(32'(bus.ready));
    push("rs_pulse_w", 4);
    width_while(1'b1, 50, n);
    check(n);
    repeat (2) tick();
    bus.pll_locked = 1'b1;
    repeat (5) tick();
    bus.pll_locked = 1'b0;
    tick();
    bus.pll_locked = 1'b1;
    push("glitch_repulse", 1);
    width_while(1'b0, 20, n);
    check(32'(n < 20));
    push("glitch_retries", 1); check(32'(dut.retries_q));
    push("glitch_run", 1);
    until_ready(100, n);
    check(32'(n < 100));
    push("glitch_relock", 0);  check(32'(bus.relock_cnt));
    push("run_retries", 0);    check(32'(dut.retries_q));

    // Lock loss in RUN
    bus.pll_locked = 1'b0;
    n = 0;
    while (bus.sys_rst_n !== 1'b0 && n < 10) begin
      tick();
      n++;
    end
    push("loss_latency_le3", 1);
    check(32'(n <= 3));
    push("loss_ready", 0);     check(32'(bus.ready));
    if (n < 3) repeat (3 - n) tick();
    bus.pll_locked = 1'b1;
    push("loss_rerun", 1);
    until_ready(100, n);
    check(32'(n < 100));
    push("loss_relock", 1);    check(32'(bus.relock_cnt));

    tmo = 0;
    for (int i = 2; i <= 257; i++) begin
      bus.pll_locked = 1'b0;
      repeat (3) tick();
      bus.pll_locked = 1'b1;
      until_ready(100, n);
      if (n >= 100) tmo++;
      if (i == 255) begin
        push("relock_255", 255);
        check(32'(bus.relock_cnt));
      end
    end
    push("relock_sat", 255);   check(32'(bus.relock_cnt));
    push("relock_tmo", 0);     check(tmo);

    // Timeout and fault
    bus.restart    = 1'b1;
    bus.pll_locked = 1'b0;
    tick();
    bus.restart = 1'b0;
    for (int p = 0; p < 3; p++) begin
      push($sformatf("to_hi_%0d", p), 4);
      width_while(1'b1, 200, n);
      check(n);
      push($sformatf("to_lo_%0d", p), 100);
      width_while(1'b0, 200, n);
      check(n);
    end
    push("fault_set", 1);      check(32'(bus.fault));
    repeat (20) tick();
    push("fault_hold", 1);     check(32'(bus.fault));
    push("fault_pll_rst", 1);  check(32'(bus.pll_reset));
    push("fault_sys_rst", 0);  check(32'(bus.sys_rst_n));
    push("fault_relock", 255); check(32'(bus.relock_cnt));
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    push("restart_fault", 0);  check(32'(bus.fault));
    push("restart_pulse_w", 4);
    width_while(1'b1, 50, n);
    check(n);

    // Restart on the RELEASE completion edge
    tick();
    bus.pll_locked = 1'b1;
    repeat (14) tick();
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    push("race_sys_rst", 0);   check(32'(bus.sys_rst_n));
    push("race_ready", 0);     check(32'(bus.ready));
    hi = 1'b0;
    repeat (10) begin
      tick();
      if (bus.sys_rst_n !== 1'b0) hi = 1'b1;
    end
    push("race_no_rise", 0);   check(32'(hi));

    // Async reset in STABLE, between clock edges
    #2;
    reset_n = 1'b0;
    #1;
    push("ar_pll_reset", 1);   check(32'(bus.pll_reset));
    push("ar_sys_rst", 0);     check(32'(bus.sys_rst_n));
    push("ar_ready", 0);       check(32'(bus.ready));
    push("ar_fault", 0);       check(32'(bus.fault));
    push("ar_relock", 0);      check(32'(bus.relock_cnt));
    tick();
    reset_n = 1'b1;
    push("ar_pulse_w", 4);
    width_while(1'b1, 50, n);
    check(n);
    push("ar_rerun", 1);
    until_ready(100, n);
    check(32'(n < 100));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
